// File: rtl/usb_host_trans_sequencer.sv
// usb_host_trans_sequencer
// Host-side USB transaction initiator. One accepted request runs a complete
// SETUP, IN or OUT transaction: token, optional data packet, response wait and,
// for IN data, the host ACK. Tx goes through a send-packet block and Rx through
// a get-packet block. Both use the same handshake: a one-cycle request pulse
// while the block is ready, one ignored cycle, then a wait for ready again.
// Optional feature macro: HOST_NAK_RETRY_EN. When it is defined, a NAK
// re-issues the transaction up to MAX_NAK_RETRY times before completing.
module usb_host_trans_sequencer #(
`ifdef HOST_NAK_RETRY_EN
   parameter logic [7:0]  MAX_NAK_RETRY = 8'd3,
`endif
   parameter logic [15:0] RESP_TIMEOUT  = 16'd1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       transReq,
   input  logic [1:0] transType,
   input  logic [6:0] tgtAddr,
   input  logic [3:0] tgtEndP,
   output logic       busy,
   output logic       transDone,
   output logic [7:0] transStatus,
   output logic       sendPacketWEn,
   input  logic       sendPacketRdy,
   output logic [3:0] sendPacketPID,
   output logic [6:0] sendPacketAddr,
   output logic [3:0] sendPacketEndP,
   output logic       getPacketREn,
   input  logic       getPacketRdy,
   input  logic [3:0] RxPID,
   input  logic       CRCError,
   input  logic       bitStuffError,
   input  logic       RxOverflow,
   input  logic       RxTimeOut,
   input  logic       dataSequence
);

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;

   localparam logic [1:0] TYPE_SETUP = 2'd0;
   localparam logic [1:0] TYPE_IN    = 2'd1;
   localparam logic [1:0] TYPE_OUT1  = 2'd3;

   // Handshake phases inside every Tx/Rx state
   localparam logic [1:0] PH_ISSUE = 2'd0;   // wait for ready, then request
   localparam logic [1:0] PH_PULSE = 2'd1;   // request pulse is on the port
   localparam logic [1:0] PH_SKIP  = 2'd2;   // ready ignored for one cycle
   localparam logic [1:0] PH_WAIT  = 2'd3;   // wait for ready = finished

   typedef enum logic [2:0] {IDLE, TOKEN, DATA, RESP, EVAL, HACK, DONE} stateT;

   stateT       stateReg, stateNext;
   logic [1:0]  phaseReg, phaseNext;
   logic [15:0] wdReg, wdNext;
   logic [1:0]  typeReg, typeNext;
   logic [6:0]  addrReg, addrNext;
   logic [3:0]  endPReg, endPNext;
   logic [3:0]  pidReg, pidNext;
   logic        wEnReg, wEnNext;
   logic        rEnReg, rEnNext;
   logic [7:0]  statusReg, statusNext;
   logic [3:0]  rxPidReg, rxPidNext;
   logic [3:0]  rxFlagsReg, rxFlagsNext;
   logic        rxSeqReg, rxSeqNext;
   logic [3:0]  txPid;
   logic        timeoutHit;
`ifdef HOST_NAK_RETRY_EN
   logic [7:0]  retryReg, retryNext;
   logic [7:0]  retryInc;

   assign retryInc = (retryReg == 8'hFF) ? retryReg : retryReg + 8'd1;
`endif

   // Expiry is detected one cycle early so transDone lands exactly
   // RESP_TIMEOUT cycles after the receive request.
   assign timeoutHit = ({1'b0, wdReg} + 17'd1) >= {1'b0, RESP_TIMEOUT};

   // PID of the packet the current Tx state sends
   always_comb begin
      txPid = PID_ACK;
      if (stateReg == TOKEN) begin
         case (typeReg)
            TYPE_SETUP: txPid = PID_SETUP;
            TYPE_IN:    txPid = PID_IN;
            default:    txPid = PID_OUT;
         endcase
      end else if (stateReg == DATA) begin
         txPid = (typeReg == TYPE_OUT1) ? PID_DATA1 : PID_DATA0;
      end
   end

   // Next-state, handshake and status logic
   always_comb begin
      stateNext   = stateReg;
      phaseNext   = phaseReg;
      typeNext    = typeReg;
      addrNext    = addrReg;
      endPNext    = endPReg;
      pidNext     = pidReg;
      wEnNext     = 1'b0;
      rEnNext     = 1'b0;
      statusNext  = statusReg;
      rxPidNext   = rxPidReg;
      rxFlagsNext = rxFlagsReg;
      rxSeqNext   = rxSeqReg;
`ifdef HOST_NAK_RETRY_EN
      retryNext   = retryReg;
`endif
      case (stateReg)
         IDLE: begin
            if (transReq) begin
               typeNext   = transType;
               addrNext   = tgtAddr;
               endPNext   = tgtEndP;
               statusNext = 8'h00;
               phaseNext  = PH_ISSUE;
               stateNext  = TOKEN;
`ifdef HOST_NAK_RETRY_EN
               retryNext  = 8'd0;
`endif
            end
         end
         TOKEN, DATA, HACK: begin
            case (phaseReg)
               PH_ISSUE: begin
                  if (sendPacketRdy) begin
                     wEnNext   = 1'b1;
                     pidNext   = txPid;
                     phaseNext = PH_PULSE;
                  end
               end
               PH_PULSE: phaseNext = PH_SKIP;
               PH_SKIP:  phaseNext = PH_WAIT;
               default: begin
                  if (sendPacketRdy) begin
                     phaseNext = PH_ISSUE;
                     if (stateReg == TOKEN) begin
                        stateNext = (typeReg == TYPE_IN) ? RESP : DATA;
                     end else if (stateReg == DATA) begin
                        stateNext = RESP;
                     end else begin
                        statusNext[7] = 1'b1;
                        stateNext     = DONE;
                     end
                  end
               end
            endcase
         end
         RESP: begin
            if (phaseReg == PH_ISSUE) begin
               if (getPacketRdy) begin
                  rEnNext   = 1'b1;
                  phaseNext = PH_PULSE;
               end
            end else if (phaseReg == PH_WAIT && getPacketRdy) begin
               rxPidNext   = RxPID;
               rxFlagsNext = {RxTimeOut, RxOverflow, bitStuffError, CRCError};
               rxSeqNext   = dataSequence;
               phaseNext   = PH_ISSUE;
               stateNext   = EVAL;
            end else if (timeoutHit) begin
               statusNext[3] = 1'b1;
               phaseNext     = PH_ISSUE;
               stateNext     = DONE;
            end else if (phaseReg != PH_WAIT) begin
               phaseNext = phaseReg + 2'd1;
            end
         end
         EVAL: begin
            phaseNext = PH_ISSUE;
            stateNext = DONE;
            if (|rxFlagsReg) begin
               // Receive errors outrank whatever PID was decoded
               statusNext[3:0] = rxFlagsReg;
            end else if (rxPidReg == PID_NAK) begin
`ifdef HOST_NAK_RETRY_EN
               retryNext = retryInc;
               if (retryInc <= MAX_NAK_RETRY) begin
                  statusNext = 8'h00;
                  stateNext  = TOKEN;
               end else begin
                  statusNext[4] = 1'b1;
               end
`else
               statusNext[4] = 1'b1;
`endif
            end else if (rxPidReg == PID_STALL) begin
               statusNext[5] = 1'b1;
            end else if (typeReg == TYPE_IN) begin
               if (rxPidReg == PID_DATA0 || rxPidReg == PID_DATA1) begin
                  statusNext[6] = rxSeqReg;
                  stateNext     = HACK;
               end else begin
                  statusNext[3] = 1'b1;
               end
            end else if (rxPidReg == PID_ACK) begin
               statusNext[7] = 1'b1;
            end else begin
               statusNext[3:0] = rxFlagsReg;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      // Watchdog restarts on every state entry and is held at zero until the
      // request pulse, so it counts cycles since that pulse.
      if (stateNext != stateReg || phaseNext <= PH_PULSE) begin
         wdNext = 16'd0;
      end else begin
         wdNext = (wdReg == 16'hFFFF) ? wdReg : wdReg + 16'd1;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg   <= IDLE;
         phaseReg   <= PH_ISSUE;
         wdReg      <= 16'd0;
         typeReg    <= 2'd0;
         addrReg    <= 7'd0;
         endPReg    <= 4'd0;
         pidReg     <= 4'd0;
         wEnReg     <= 1'b0;
         rEnReg     <= 1'b0;
         statusReg  <= 8'd0;
         rxPidReg   <= 4'd0;
         rxFlagsReg <= 4'd0;
         rxSeqReg   <= 1'b0;
`ifdef HOST_NAK_RETRY_EN
         retryReg   <= 8'd0;
`endif
      end else begin
         stateReg   <= stateNext;
         phaseReg   <= phaseNext;
         wdReg      <= wdNext;
         typeReg    <= typeNext;
         addrReg    <= addrNext;
         endPReg    <= endPNext;
         pidReg     <= pidNext;
         wEnReg     <= wEnNext;
         rEnReg     <= rEnNext;
         statusReg  <= statusNext;
         rxPidReg   <= rxPidNext;
         rxFlagsReg <= rxFlagsNext;
         rxSeqReg   <= rxSeqNext;
`ifdef HOST_NAK_RETRY_EN
         retryReg   <= retryNext;
`endif
      end
   end

   assign busy           = (stateReg != IDLE);
   assign transDone      = (stateReg == DONE);
   assign transStatus    = statusReg;
   assign sendPacketWEn  = wEnReg;
   assign sendPacketPID  = pidReg;
   assign sendPacketAddr = addrReg;
   assign sendPacketEndP = endPReg;
   assign getPacketREn   = rEnReg;

endmodule

// File: tb/tb_usb_host_trans_sequencer.sv
// Testbench for usb_host_trans_sequencer: behavioural send/get packet models,
// a transaction-level reference model feeding a scoreboard queue, and a
// monitor that checks every completed transaction against it.
module tb_usb_host_trans_sequencer;

   localparam logic [15:0] TO = 16'd16;
   localparam int MAXR = 2;
`ifdef HOST_NAK_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       transReq;
   logic [1:0] transType;
   logic [6:0] tgtAddr;
   logic [3:0] tgtEndP;
   logic       busy, transDone;
   logic [7:0] transStatus;
   logic       sendPacketWEn, sendPacketRdy;
   logic [3:0] sendPacketPID;
   logic [6:0] sendPacketAddr;
   logic [3:0] sendPacketEndP;
   logic       getPacketREn, getPacketRdy;
   logic [3:0] RxPID;
   logic       CRCError, bitStuffError, RxOverflow, RxTimeOut, dataSequence;

   always #5 clk = ~clk;

   usb_host_trans_sequencer #(
`ifdef HOST_NAK_RETRY_EN
      .MAX_NAK_RETRY(8'd2),
`endif
      .RESP_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .transReq(transReq), .transType(transType),
      .tgtAddr(tgtAddr), .tgtEndP(tgtEndP), .busy(busy), .transDone(transDone),
      .transStatus(transStatus), .sendPacketWEn(sendPacketWEn),
      .sendPacketRdy(sendPacketRdy), .sendPacketPID(sendPacketPID),
      .sendPacketAddr(sendPacketAddr), .sendPacketEndP(sendPacketEndP),
      .getPacketREn(getPacketREn), .getPacketRdy(getPacketRdy), .RxPID(RxPID),
      .CRCError(CRCError), .bitStuffError(bitStuffError), .RxOverflow(RxOverflow),
      .RxTimeOut(RxTimeOut), .dataSequence(dataSequence)
   );

   typedef struct {
      logic [3:0] pid;
      logic [3:0] flags;
      logic       seq;
      bit         hang;
   } respT;

   typedef struct {
      logic [7:0]  status;
      logic [31:0] pids;
      int          n;
      logic [6:0]  addr;
      logic [3:0]  endp;
      bit          chkLat;
   } expT;

   respT respQ[$];
   expT  expQ[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cycle = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic summary();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
   endtask

   // Monitor: collects Tx PIDs per transaction and checks each completion
   initial begin : monitor
      logic [31:0] seenPids;
      int          seenN;
      logic [6:0]  seenAddr;
      logic [3:0]  seenEndP;
      int          renCycle;
      expT         x;
      seenPids = 0; seenN = 0; seenAddr = 0; seenEndP = 0; renCycle = 0;
      forever begin
         @(negedge clk);
         cycle++;
         if (rst) begin
            seenPids = 0;
            seenN    = 0;
         end else begin
            if (sendPacketWEn) begin
               if (seenN == 0) begin
                  seenAddr = sendPacketAddr;
                  seenEndP = sendPacketEndP;
               end
               seenPids = {seenPids[27:0], sendPacketPID};
               seenN++;
            end
            if (getPacketREn) renCycle = cycle;
            if (transDone) begin
               if (expQ.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected transDone: got status %h, expected no completion", transStatus);
               end else begin
                  x = expQ.pop_front();
                  check("status", {24'd0, transStatus}, {24'd0, x.status});
                  check("tx pid sequence", seenPids, x.pids);
                  check("tx packet count", seenN, x.n);
                  check("token addr", {25'd0, seenAddr}, {25'd0, x.addr});
                  check("token endp", {28'd0, seenEndP}, {28'd0, x.endp});
                  if (x.chkLat) check("timeout latency", cycle - renCycle, 32'd16);
               end
               seenPids = 0;
               seenN    = 0;
            end
         end
      end
   end

   // Send-packet block model: busy for a few cycles after each request
   initial begin : sendModel
      int cnt;
      cnt = 0;
      sendPacketRdy = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            sendPacketRdy = 1'b1;
            cnt = 0;
         end else if (sendPacketWEn) begin
            sendPacketRdy = 1'b0;
            cnt = $urandom_range(1, 4);
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) sendPacketRdy = 1'b1;
         end
      end
   end

   // Get-packet block model: returns the queued response, or never answers
   initial begin : getModel
      int   cnt;
      bit   hanging;
      respT r;
      cnt = 0; hanging = 0;
      r.pid = 4'h2; r.flags = 4'h0; r.seq = 1'b0; r.hang = 1'b0;
      getPacketRdy = 1'b1;
      RxPID = 4'h0; dataSequence = 1'b0;
      {RxTimeOut, RxOverflow, bitStuffError, CRCError} = 4'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            getPacketRdy = 1'b1;
            cnt = 0;
            hanging = 0;
         end else if (getPacketREn) begin
            getPacketRdy = 1'b0;
            RxPID = 4'($urandom_range(0, 15));
            if (respQ.size() > 0) r = respQ.pop_front();
            else begin
               r.pid = 4'h2; r.flags = 4'h0; r.seq = 1'b0; r.hang = 1'b0;
            end
            hanging = r.hang;
            cnt = $urandom_range(1, 5);
         end else if (hanging) begin
            if (!busy) begin
               hanging = 0;
               getPacketRdy = 1'b1;
            end
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               RxPID = r.pid;
               {RxTimeOut, RxOverflow, bitStuffError, CRCError} = r.flags;
               dataSequence = r.seq;
               getPacketRdy = 1'b1;
            end
         end
      end
   end

   task automatic randomResp(output respT r);
      int k;
      k = $urandom_range(0, 11);
      r.hang = 1'b0;
      case (k)
         0, 1, 2: r.pid = 4'h2;
         3, 4:    r.pid = 4'hA;
         5:       r.pid = 4'hE;
         6, 7:    r.pid = 4'h3;
         8, 9:    r.pid = 4'hB;
         10:      r.pid = 4'($urandom_range(0, 15));
         default: begin r.pid = 4'h0; r.hang = 1'b1; end
      endcase
      r.flags = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      r.seq   = 1'($urandom_range(0, 1));
   endtask

   // Reference model plus stimulus for one transaction. forcePid: -1 random,
   // 16 = no response at all, otherwise the PID returned on every attempt.
   task automatic runTrans(input logic [1:0] ty, input logic [6:0] a, input logic [3:0] e,
                           input int forcePid, input logic [3:0] fFlags, input logic fSeq,
                           input bit pulse);
      expT        x;
      respT       r;
      int         naks;
      int         w;
      bit         fin;
      logic [7:0] st;
      logic [3:0] tok;
      x.pids = 0; x.n = 0; x.addr = a; x.endp = e; x.chkLat = 0;
      naks = 0; fin = 0; st = 0;
      tok = (ty == 2'd0) ? 4'hD : (ty == 2'd1) ? 4'h9 : 4'h1;
      while (!fin) begin
         x.pids = {x.pids[27:0], tok}; x.n++;
         if (ty != 2'd1) begin
            x.pids = {x.pids[27:0], (ty == 2'd3) ? 4'hB : 4'h3}; x.n++;
         end
         if (forcePid >= 0) begin
            r.hang  = (forcePid == 16);
            r.pid   = forcePid[3:0];
            r.flags = fFlags;
            r.seq   = fSeq;
         end else begin
            randomResp(r);
         end
         respQ.push_back(r);
         fin = 1;
         if (r.hang) begin
            st = 8'h08;
            x.chkLat = 1;
         end else if (r.flags != 4'h0) begin
            st = {4'h0, r.flags};
         end else if (r.pid == 4'hA) begin
            naks++;
            if (RETRY_EN && naks <= MAXR) fin = 0;
            else st = 8'h10;
         end else if (r.pid == 4'hE) begin
            st = 8'h20;
         end else if (ty == 2'd1) begin
            if (r.pid == 4'h3 || r.pid == 4'hB) begin
               x.pids = {x.pids[27:0], 4'h2}; x.n++;
               st = r.seq ? 8'hC0 : 8'h80;
            end else begin
               st = 8'h08;
            end
         end else begin
            st = (r.pid == 4'h2) ? 8'h80 : 8'h00;
         end
      end
      x.status = st;
      expQ.push_back(x);

      @(negedge clk);
      transReq = 1'b1; transType = ty; tgtAddr = a; tgtEndP = e;
      @(negedge clk);
      transReq = 1'b0;
      transType = 2'($urandom); tgtAddr = 7'($urandom); tgtEndP = 4'($urandom);
      if (pulse) begin
         repeat (3) @(negedge clk);
         transReq = 1'b1;
         @(negedge clk);
         transReq = 1'b0;
      end
      w = 0;
      while (busy && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (busy) begin
         vectors++;
         miscompares++;
         $display("FAIL busy bound: still busy after %0d cycles, expected idle", w);
         summary();
         $finish;
      end
      check("status held after done", {24'd0, transStatus}, {24'd0, st});
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   // Reset asserted while a NAKed IN transaction is in flight
   task automatic resetDuringRetry();
      respT r;
      int   rens;
      int   target;
      int   w;
      target = RETRY_EN ? 2 : 1;
      r.pid = 4'hA; r.flags = 4'h0; r.seq = 1'b0; r.hang = 1'b0;
      repeat (3) respQ.push_back(r);
      @(negedge clk);
      transReq = 1'b1; transType = 2'd1; tgtAddr = 7'h33; tgtEndP = 4'h2;
      @(negedge clk);
      transReq = 1'b0;
      rens = 0; w = 0;
      while (rens < target && w < 500) begin
         if (getPacketREn) rens++;
         if (rens < target) begin
            @(negedge clk);
            w++;
         end
      end
      check("retry attempts before reset", rens, target);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      respQ.delete();
      check("busy after abort", {31'd0, busy}, 32'd0);
      check("status after abort", {24'd0, transStatus}, 32'd0);
      check("WEn after abort", {31'd0, sendPacketWEn}, 32'd0);
      repeat (30) @(negedge clk);
      check("busy stays low", {31'd0, busy}, 32'd0);
   endtask

   initial begin : stimulus
      rst = 1'b1; transReq = 1'b0; transType = 2'd0; tgtAddr = 7'd0; tgtEndP = 4'd0;
      repeat (3) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset transDone", {31'd0, transDone}, 32'd0);
      check("reset status", {24'd0, transStatus}, 32'd0);
      check("reset WEn", {31'd0, sendPacketWEn}, 32'd0);
      check("reset REn", {31'd0, getPacketREn}, 32'd0);
      check("reset PID", {28'd0, sendPacketPID}, 32'd0);
      check("reset addr", {25'd0, sendPacketAddr}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      runTrans(2'd0, 7'h05, 4'h0, 2,    4'h0, 1'b0, 1'b0);   // SETUP, ACK
      runTrans(2'd1, 7'h12, 4'h1, 'hB,  4'h0, 1'b1, 1'b0);   // IN, DATA1
      runTrans(2'd3, 7'h44, 4'h7, 'hE,  4'h0, 1'b0, 1'b0);   // OUT DATA1, STALL
      runTrans(2'd1, 7'h21, 4'h3, 3,    4'h1, 1'b0, 1'b0);   // IN, DATA0 + CRC
      runTrans(2'd1, 7'h60, 4'h5, 16,   4'h0, 1'b0, 1'b1);   // IN, timeout
      runTrans(2'd1, 7'h0A, 4'h2, 'hA,  4'h0, 1'b0, 1'b0);   // IN, NAK always
      runTrans(2'd2, 7'h7F, 4'hF, 'hA,  4'h0, 1'b0, 1'b0);   // OUT DATA0, NAK always

      for (int i = 0; i < 60; i++) begin
         runTrans(2'($urandom_range(0, 3)), 7'($urandom), 4'($urandom), -1, 4'h0, 1'b0,
                  1'($urandom_range(0, 1)));
      end

      resetDuringRetry();
      check("scoreboard drained", expQ.size(), 32'd0);
      summary();
      $finish;
   end

endmodule
